// File: rtl/thumb_encoder.sv
// thumb_encoder: packs one abstract micro-operation per transaction into a
// 16-bit Thumb instruction, choosing the encoding form, range-checking the
// register/immediate fields and tagging each instruction with a halfword
// program address taken from an internal counter.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low. On the output side out_valid/out_instr/out_addr stay
// stable until out_ready is seen high. Ready never depends on the same-side
// valid.
module thumb_encoder #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              use_imm,
    input  logic [2:0]        rd,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [31:0]       imm,
    input  logic [3:0]        cond,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        err_count
);

    // Micro-operation codes
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_LSL = 4'd2;
    localparam logic [3:0] OP_MOV = 4'd3;
    localparam logic [3:0] OP_CMP = 4'd4;
    localparam logic [3:0] OP_EOR = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_B   = 4'd8;

    localparam logic [3:0] COND_AL  = 4'b1110;
    localparam logic [3:0] COND_BAD = 4'b1111;

    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] take_addr;
    logic [15:0]       enc_instr;
    logic              enc_legal;
    logic              accept;
    logic              accept_legal;
    logic              accept_illegal;

    // Field range checks; unsigned forms treat imm as a 32-bit unsigned value,
    // branch offsets as signed (upper bits must be a pure sign extension).
    logic imm_lt8;
    logic imm_lt32;
    logic imm_lt256;
    logic br_long_ok;
    logic br_short_ok;
    logic sub_sel;

    assign imm_lt8     = (imm[31:3] == 29'd0);
    assign imm_lt32    = (imm[31:5] == 27'd0);
    assign imm_lt256   = (imm[31:8] == 24'd0);
    assign br_long_ok  = (imm[31:10] == 22'd0) || (imm[31:10] == {22{1'b1}});
    assign br_short_ok = (imm[31:7] == 25'd0) || (imm[31:7] == {25{1'b1}});
    assign sub_sel     = (op == OP_SUB);

    assign in_ready       = !reset && (!out_valid || out_ready);
    assign accept         = in_valid && in_ready;
    assign accept_legal   = accept && enc_legal;
    assign accept_illegal = accept && !enc_legal;

    // A base_load accompanying an accept re-bases the accepted instruction itself.
    assign take_addr = base_load ? base_addr : counter;

    // Encoder: pick the form and pack the fields; anything out of range is illegal.
    always_comb begin
        enc_instr = 16'h0000;
        enc_legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                if (!use_imm) begin
                    enc_instr = {6'b000110, sub_sel, rm, rn, rd};
                    enc_legal = 1'b1;
                end else if (imm_lt8) begin
                    enc_instr = {6'b000111, sub_sel, imm[2:0], rn, rd};
                    enc_legal = 1'b1;
                end else if ((rd == rn) && imm_lt256) begin
                    enc_instr = {4'b0011, sub_sel, rd, imm[7:0]};
                    enc_legal = 1'b1;
                end
            end
            OP_LSL: begin
                enc_instr = {5'b00000, imm[4:0], rm, rd};
                enc_legal = imm_lt32;
            end
            OP_MOV: begin
                enc_instr = {5'b00100, rd, imm[7:0]};
                enc_legal = imm_lt256;
            end
            OP_CMP: begin
                enc_instr = {5'b00101, rn, imm[7:0]};
                enc_legal = imm_lt256;
            end
            OP_EOR: begin
                enc_instr = {10'b0100000001, rm, rd};
                enc_legal = 1'b1;
            end
            OP_LDR: begin
                enc_instr = {5'b01101, imm[4:0], rn, rd};
                enc_legal = imm_lt32;
            end
            OP_STR: begin
                enc_instr = {5'b01100, imm[4:0], rn, rd};
                enc_legal = imm_lt32;
            end
            OP_B: begin
                if (cond == COND_AL) begin
                    enc_instr = {5'b11100, imm[10:0]};
                    enc_legal = br_long_ok;
                end else if (cond != COND_BAD) begin
                    enc_instr = {4'b1101, cond, imm[7:0]};
                    enc_legal = br_short_ok;
                end
            end
            default: begin
                enc_instr = 16'h0000;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Output register and address counter: reload on a legal accept, drop
    // valid on a bare output handshake, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= 16'h0000;
            out_addr  <= '0;
            counter   <= RESET_ADDR;
        end else begin
            if (accept_legal) begin
                out_valid <= 1'b1;
                out_instr <= enc_instr;
                out_addr  <= take_addr;
                counter   <= take_addr + ADDR_W'(1);
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (base_load) begin
                    counter <= base_addr;
                end
            end
        end
    end

    // Error reporting: one-cycle pulse per rejected request plus a saturating tally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_illegal <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            err_illegal <= accept_illegal;
            if (accept_illegal && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_thumb_encoder.sv
// Testbench for thumb_encoder: directed scenarios, scoreboard on the output port.
module tb_thumb_encoder;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic              use_imm;
    logic [2:0]        rd;
    logic [2:0]        rn;
    logic [2:0]        rm;
    logic [31:0]       imm;
    logic [3:0]        cond;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {instr, addr} of every instruction expected on the output
    logic [15+ADDR_W:0] exp_q[$];
    logic [15+ADDR_W:0] mon_exp;
    logic [ADDR_W-1:0]  exp_addr;

    thumb_encoder #(.ADDR_W(ADDR_W), .RESET_ADDR(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .use_imm     (use_imm),
        .rd          (rd),
        .rn          (rn),
        .rm          (rm),
        .imm         (imm),
        .cond        (cond),
        .base_load   (base_load),
        .base_addr   (base_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .err_count   (err_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: pops the scoreboard whenever the consumer takes an instruction
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got instr=%h addr=%h, queue empty", out_instr, out_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_instr, out_addr} !== mon_exp) begin
                    errors++;
                    $display("FAIL out_txn got instr=%h addr=%h expected instr=%h addr=%h",
                             out_instr, out_addr, mon_exp[15+ADDR_W:ADDR_W], mon_exp[ADDR_W-1:0]);
                end
            end
        end
    end

    task automatic set_req(input logic [3:0] o, input logic ui, input logic [2:0] d,
                           input logic [2:0] n, input logic [2:0] m,
                           input logic [31:0] im, input logic [3:0] c);
        op = o; use_imm = ui; rd = d; rn = n; rm = m; imm = im; cond = c;
    endtask

    // Driver: present one request (called just after a posedge), wait for it
    // to be accepted, record its expectation, return just after the accept edge.
    task automatic send(input logic [3:0] o, input logic ui, input logic [2:0] d,
                        input logic [2:0] n, input logic [2:0] m, input logic [31:0] im,
                        input logic [3:0] c, input logic bl, input logic [ADDR_W-1:0] ba,
                        input logic legal, input logic [15:0] exp_instr);
        logic [ADDR_W-1:0] a;
        int waited;
        set_req(o, ui, d, n, m, im, c);
        base_load = bl;
        base_addr = ba;
        in_valid  = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout op=%0d in_ready=%b expected 1 within 20 cycles", o, in_ready);
        end else if (legal) begin
            a = bl ? ba : exp_addr;
            exp_q.push_back({exp_instr, a});
            exp_addr = a + 8'd1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        base_load = 1'b0;
    endtask

    // Called just after an illegal accept edge
    task automatic check_illegal(input logic [7:0] exp_cnt, input string name);
        checks++;
        if (err_illegal !== 1'b1 || err_count !== exp_cnt || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s got err_illegal=%b err_count=%0d out_valid=%b expected 1 %0d 0",
                     name, err_illegal, err_count, out_valid, exp_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse_end got err_illegal=%b expected 0", name, err_illegal);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; base_load = 1'b0; base_addr = '0;
        set_req(4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0, 4'd0);
        exp_addr = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 16'h0 || out_addr !== 8'h0 ||
            err_illegal !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got v=%b i=%h a=%h ei=%b ec=%0d rdy=%b expected 0 0000 00 0 0 0",
                     out_valid, out_instr, out_addr, err_illegal, err_count, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_add();
        send(4'd0, 1'b0, 3'd1, 3'd2, 3'd3, 32'd0, 4'd0, 1'b0, 8'h0, 1'b1, 16'h18D1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency got out_valid=%b expected 1", out_valid);
        end
        send(4'd0, 1'b1, 3'd1, 3'd2, 3'd0, 32'd5, 4'd0, 1'b0, 8'h0, 1'b1, 16'h1D51);
        send(4'd0, 1'b1, 3'd4, 3'd4, 3'd0, 32'd200, 4'd0, 1'b0, 8'h0, 1'b1, 16'h34C8);
    endtask

    task automatic test_misc();
        send(4'd6, 1'b0, 3'd0, 3'd1, 3'd0, 32'd4, 4'd0, 1'b0, 8'h0, 1'b1, 16'h6908);
        send(4'd5, 1'b0, 3'd2, 3'd6, 3'd5, 32'd0, 4'd0, 1'b0, 8'h0, 1'b1, 16'h406A);
        send(4'd3, 1'b0, 3'd3, 3'd0, 3'd0, 32'd255, 4'd0, 1'b0, 8'h0, 1'b1, 16'h23FF);
        send(4'd2, 1'b0, 3'd1, 3'd0, 3'd2, 32'd32, 4'd0, 1'b0, 8'h0, 1'b0, 16'h0);
        check_illegal(8'd1, "lsl_imm32");
    endtask

    task automatic test_branch();
        send(4'd8, 1'b0, 3'd0, 3'd0, 3'd0, 32'hFFFF_FFFE, 4'b1110, 1'b0, 8'h0, 1'b1, 16'hE7FE);
        send(4'd8, 1'b0, 3'd0, 3'd0, 3'd0, 32'hFFFF_FF80, 4'b0000, 1'b0, 8'h0, 1'b1, 16'hD080);
        send(4'd8, 1'b0, 3'd0, 3'd0, 3'd0, 32'd200, 4'b0000, 1'b0, 8'h0, 1'b0, 16'h0);
        check_illegal(8'd2, "b_short_range");
        send(4'd8, 1'b0, 3'd0, 3'd0, 3'd0, 32'd4, 4'b1111, 1'b0, 8'h0, 1'b0, 16'h0);
        check_illegal(8'd3, "b_cond_1111");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(4'd3, 1'b0, 3'd1, 3'd0, 3'd0, 32'h11, 4'd0, 1'b0, 8'h0, 1'b1, 16'h2111);
        set_req(4'd3, 1'b0, 3'd2, 3'd0, 3'd0, 32'h22, 4'd0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 16'h2111 ||
                out_addr !== exp_q[0][ADDR_W-1:0]) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got rdy=%b v=%b i=%h a=%h expected 0 1 2111 %h",
                         k, in_ready, out_valid, out_instr, out_addr, exp_q[0][ADDR_W-1:0]);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd3, 1'b0, 3'd2, 3'd0, 3'd0, 32'h22, 4'd0, 1'b0, 8'h0, 1'b1, 16'h2222);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  t_op[4];
        logic        t_ui[4];
        logic [2:0]  t_rd[4];
        logic [2:0]  t_rn[4];
        logic [2:0]  t_rm[4];
        logic [31:0] t_imm[4];
        logic [15:0] t_exp[4];
        t_op = '{4'd1, 4'd4, 4'd7, 4'd1};
        t_ui = '{1'b0, 1'b0, 1'b0, 1'b1};
        t_rd = '{3'd1, 3'd0, 3'd6, 3'd0};
        t_rn = '{3'd2, 3'd5, 3'd7, 3'd4};
        t_rm = '{3'd3, 3'd0, 3'd0, 3'd0};
        t_imm = '{32'd0, 32'h3C, 32'd31, 32'd7};
        t_exp = '{16'h1AD1, 16'h2D3C, 16'h67FE, 16'h1FE0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(t_op[i], t_ui[i], t_rd[i], t_rn[i], t_rm[i], t_imm[i], 4'd0);
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready item %0d got in_ready=%b expected 1", i, in_ready);
            end
            exp_q.push_back({t_exp[i], exp_addr});
            exp_addr = exp_addr + 8'd1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        send(4'd2, 1'b0, 3'd2, 3'd0, 3'd3, 32'd31, 4'd0, 1'b1, 8'hFE, 1'b1, 16'h07DA);
        send(4'd3, 1'b0, 3'd0, 3'd0, 3'd0, 32'd1, 4'd0, 1'b0, 8'h0, 1'b1, 16'h2001);
        send(4'd5, 1'b0, 3'd7, 3'd0, 3'd7, 32'd0, 4'd0, 1'b0, 8'h0, 1'b1, 16'h407F);
        checks++;
        if (out_addr !== 8'h00) begin
            errors++;
            $display("FAIL wrap_addr got out_addr=%h expected 00", out_addr);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'd3, 1'b0, 3'd4, 3'd0, 3'd0, 32'h44, 4'd0, 1'b0, 8'h0, 1'b1, 16'h2444);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || err_count !== 8'd3) begin
            errors++;
            $display("FAIL pre_reset got out_valid=%b err_count=%0d expected 1 3", out_valid, err_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 16'h0 || out_addr !== 8'h0 ||
            err_illegal !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b i=%h a=%h ei=%b ec=%0d rdy=%b expected 0 0000 00 0 0 0",
                     out_valid, out_instr, out_addr, err_illegal, err_count, in_ready);
        end
        exp_q.delete();
        exp_addr = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(4'd3, 1'b0, 3'd5, 3'd0, 3'd0, 32'h55, 4'd0, 1'b0, 8'h0, 1'b1, 16'h2555);
        checks++;
        if (out_addr !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_addr got out_addr=%h expected 00", out_addr);
        end
    endtask

    task automatic drain();
        int waited = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got pending=%0d out_valid=%b expected 0 0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_misc();
        test_branch();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
